ldpc_bitflip_decode: RTL and testbench
======================================

# ldpc_bitflip_decode

Hard-decision bit-flipping LDPC decoder; the receive-side counterpart of `encode`, which it sits directly downstream of (after the channel). It accepts an N-bit received word plus the parity-check matrix H. It iterates syndrome-check / flip until the syndrome is zero or an iteration limit is hit. It then presents the corrected codeword, the K systematic info bits, and a success flag.

## Interface
Parameters:
- N, 6, codeword length
- K, 3, info bits; N-K parity checks
- MAX_ITER, 8, maximum flip iterations (0 allowed)

Ports:
- clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- i_valid  in  1  input word present
- o_ready  out  1  decoder idle, can accept
- i_word  in  N  received hard-decision word
- i_h  in  (N-K)*N  parity-check matrix, H[r][c] = i_h[r*N + c]
- o_valid  out  1  one-cycle result strobe
- o_ok  out  1  final syndrome zero
- o_codeword  out  N  decoded word
- o_info_bits  out  K  o_codeword[K-1:0]
- o_iter  out  clog2(MAX_ITER+1)  iterations used (only with LDPC_DEC_ITER_CNT_EN)

Clock is `clk`; reset `i_rst_n` is asynchronous, active-low.

## Operation
- Codeword layout matches `encode`: info bits in [K-1:0], parity in [N-1:K].
- FSM states:
  - IDLE: o_ready=1. On i_valid: register i_word into the working word, register i_h, set iter=0, go to CHECK. i_h must be captured at accept; later changes are ignored.
  - CHECK: syndrome s[r] = XOR over c of (H[r][c] & word[c]).
    - s==0: go to DONE, ok=1.
    - else if iter==MAX_ITER: go to DONE, ok=0.
    - else go to FLIP.
  - FLIP: unsat[c] = count of rows r with s[r]=1 and H[r][c]=1; max = max over c. Every bit with unsat[c]==max is inverted (max≥1 is guaranteed here); iter+=1; go to CHECK.
  - DONE: o_valid=1 for exactly this cycle with o_ok/o_codeword/o_info_bits; go to IDLE.
- o_codeword/o_info_bits/o_ok hold their values after DONE until the next accept.
- Widths:
  - unsat counters: clog2(N-K+1) bits, unsigned.
  - iter: clog2(MAX_ITER+1) bits; cannot exceed MAX_ITER.
- All-zero H: syndrome is always zero, so the result is ok=1 with the word unchanged.

## Timing
- Reset (any state, including mid-decode): state=IDLE; o_ready=1, o_valid=0, o_ok=0, o_codeword=0, iter=0. An in-flight word is discarded.
- Accept at edge t (i_valid & o_ready). Clean word: CHECK at cycle t+1, o_valid high at t+2.
- Each flip iteration adds 2 cycles. Latency = 2 + 2*iterations cycles from accept to o_valid.
- o_ready=0 from the cycle after accept through DONE. i_valid while busy is ignored, not queued.
- o_ready returns to 1 the cycle after o_valid, so the next accept can coincide with that cycle.

## Configuration
- LDPC_DEC_ITER_CNT_EN defined: port o_iter exists. It carries the iteration count of the result, valid with o_valid and held alongside o_codeword; reset value 0.
- Undefined: port o_iter and its output register are absent. Decode behaviour is identical either way.

## Structure
- Package `ldpc_pkg`:
  - FSM state enum (IDLE, CHECK, FLIP, DONE)
  - localparams for counter widths (clog2 of N-K+1 and MAX_ITER+1)
- Sub-module `ldpc_syndrome`: combinational; inputs word and H, outputs s[N-K-1:0], the unsat count vector, and the flip mask (bits equal to max). The top holds the FSM and registers.

## Test plan
All cases use N=6, K=3, i_h=18'h2558B (rows 0x0B, 0x16, 0x25).
- Clean word: i_word=6'h1A (info 3'b010) → o_valid 2 cycles after accept, o_ok=1, o_codeword=6'h1A, o_info_bits=3'b010, o_iter=0.
- Single error: i_word=6'h18 → one iteration flips bit1; o_valid 4 cycles after accept, o_codeword=6'h1A, o_ok=1, o_iter=1.
- Miscorrection: i_word=6'h3A → 0x1F → 0x1D; o_ok=1, o_codeword=6'h1D, o_iter=2, latency 6 cycles.
- MAX_ITER=0, i_word=6'h18 → o_valid 2 cycles after accept, o_ok=0, o_codeword=6'h18.
- Busy/back-to-back: hold i_valid with 6'h18 then 6'h1A.
  - Second word is not accepted until o_ready returns.
  - Two o_valid pulses result, both with o_codeword=6'h1A.
- Reset mid-decode: assert i_rst_n=0 during FLIP → outputs immediately 0, o_ready=1, no o_valid. A subsequent 6'h1A decodes normally.

Source files
------------

// File: rtl/ldpc_pkg.sv
// ----------------------------------------------------------------------------
// ldpc_pkg
// Shared types and sizing helpers for the bit-flipping LDPC decoder.
//   ldpc_state_e : decoder FSM states (IDLE, CHECK, FLIP, DONE)
//   cnt_w()      : bits needed to count 0..max_val (never less than 1)
//   *_W_DEF      : counter widths for the default N=6, K=3, MAX_ITER=8 build
// ----------------------------------------------------------------------------
package ldpc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    FLIP  = 2'd2,
    DONE  = 2'd3
  } ldpc_state_e;

  // clog2(max_val+1), clamped to 1 so a zero limit still yields a legal vector.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int LDPC_N_DEF        = 6;
  localparam int LDPC_K_DEF        = 3;
  localparam int LDPC_MAX_ITER_DEF = 8;
  localparam int UNSAT_W_DEF       = cnt_w(LDPC_N_DEF - LDPC_K_DEF);
  localparam int ITER_W_DEF        = cnt_w(LDPC_MAX_ITER_DEF);

endpackage

// File: rtl/ldpc_syndrome.sv
// ----------------------------------------------------------------------------
// ldpc_syndrome
// Combinational syndrome / flip-decision logic for one bit-flipping step.
//   word      : current hard-decision word, N bits
//   h         : parity-check matrix, H[r][c] = h[r*N + c]
//   syn       : syndrome, one bit per check row
//   unsat     : per-column count of failing checks, packed UW bits per column
//   flip_mask : columns whose count equals the maximum (zero if max is 0)
// ----------------------------------------------------------------------------
module ldpc_syndrome
  import ldpc_pkg::*;
#(
  parameter int N = 6,
  parameter int K = 3
) (
  input  logic [N-1:0]               word,
  input  logic [(N-K)*N-1:0]         h,
  output logic [N-K-1:0]             syn,
  output logic [N*cnt_w(N-K)-1:0]    unsat,
  output logic [N-1:0]               flip_mask
);

  localparam int M  = N - K;
  localparam int UW = cnt_w(M);

  logic [UW-1:0] cnt [N];
  logic [UW-1:0] max_cnt;

  always_comb begin
    syn = '0;
    for (int r = 0; r < M; r++) begin
      for (int c = 0; c < N; c++) begin
        syn[r] = syn[r] ^ (h[r*N + c] & word[c]);
      end
    end
  end

  always_comb begin
    max_cnt = '0;
    for (int c = 0; c < N; c++) begin
      cnt[c] = '0;
      for (int r = 0; r < M; r++) begin
        if (syn[r] && h[r*N + c]) cnt[c] = cnt[c] + UW'(1);
      end
      if (cnt[c] > max_cnt) max_cnt = cnt[c];
    end
  end

  // A zero maximum means no failing check touches any column; flip nothing.
  always_comb begin
    unsat     = '0;
    flip_mask = '0;
    for (int c = 0; c < N; c++) begin
      unsat[c*UW +: UW] = cnt[c];
      flip_mask[c]      = (max_cnt != '0) && (cnt[c] == max_cnt);
    end
  end

endmodule

// File: rtl/ldpc_bitflip_decode.sv
// ----------------------------------------------------------------------------
// ldpc_bitflip_decode
// Hard-decision bit-flipping LDPC decoder. Accepts a received word and the
// parity-check matrix, alternates syndrome check / flip until the syndrome is
// zero or MAX_ITER flips were made, then strobes the result for one cycle.
//   clk, i_rst_n  : clock (rising edge), asynchronous active-low reset
//   i_valid       : word present; taken when o_ready is high
//   o_ready       : decoder idle
//   i_word, i_h   : received word and H matrix (H[r][c] = i_h[r*N + c])
//   o_valid       : one-cycle result strobe
//   o_ok          : final syndrome was zero
//   o_codeword    : decoded word; o_info_bits = o_codeword[K-1:0]
//   o_iter        : flips used (present only with LDPC_DEC_ITER_CNT_EN)
// Results hold after the strobe until the next result is produced.
// Optional feature macro: LDPC_DEC_ITER_CNT_EN
// ----------------------------------------------------------------------------
module ldpc_bitflip_decode
  import ldpc_pkg::*;
#(
  parameter int N        = 6,
  parameter int K        = 3,
  parameter int MAX_ITER = 8
) (
  input  logic                        clk,
  input  logic                        i_rst_n,
  input  logic                        i_valid,
  output logic                        o_ready,
  input  logic [N-1:0]                i_word,
  input  logic [(N-K)*N-1:0]          i_h,
  output logic                        o_valid,
  output logic                        o_ok,
  output logic [N-1:0]                o_codeword,
  output logic [K-1:0]                o_info_bits
`ifdef LDPC_DEC_ITER_CNT_EN
  ,
  output logic [cnt_w(MAX_ITER)-1:0]  o_iter
`endif
);

  localparam int M  = N - K;
  localparam int UW = cnt_w(M);
  localparam int IW = cnt_w(MAX_ITER);

  ldpc_state_e         state, state_nxt;
  logic [N-1:0]        word_q;
  logic [M*N-1:0]      h_q;
  logic [IW-1:0]       iter_q;
  logic [M-1:0]        syn;
  logic [N-1:0]        flip_mask;
  logic [N*UW-1:0]     unused_unsat;   // per-column counts kept for debug visibility
  logic                accept;
  logic                syn_zero;
  logic                iter_at_max;

  ldpc_syndrome #(.N(N), .K(K)) u_syndrome (
    .word      (word_q),
    .h         (h_q),
    .syn       (syn),
    .unsat     (unused_unsat),
    .flip_mask (flip_mask)
  );

  assign syn_zero    = (syn == '0);
  assign iter_at_max = (iter_q == IW'(MAX_ITER));

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        o_ready = 1'b1;
        accept  = i_valid;
        if (i_valid) state_nxt = CHECK;
      end
      CHECK: begin
        if (syn_zero || iter_at_max) state_nxt = DONE;
        else                         state_nxt = FLIP;
      end
      FLIP: state_nxt = CHECK;
      DONE: begin
        o_valid   = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control and visible results: cleared by reset.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      iter_q     <= '0;
      o_ok       <= 1'b0;
      o_codeword <= '0;
`ifdef LDPC_DEC_ITER_CNT_EN
      o_iter     <= '0;
`endif
    end else begin
      if (accept) iter_q <= '0;
      else if (state == FLIP) iter_q <= iter_q + IW'(1);
      // Results are latched on the CHECK -> DONE transition so they line up
      // with o_valid and hold afterwards.
      if (state == CHECK && (syn_zero || iter_at_max)) begin
        o_ok       <= syn_zero;
        o_codeword <= word_q;
`ifdef LDPC_DEC_ITER_CNT_EN
        o_iter     <= iter_q;
`endif
      end
    end
  end

  // Working word and captured H: datapath, no reset needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      word_q <= i_word;
      h_q    <= i_h;
    end else if (state == FLIP) begin
      word_q <= word_q ^ flip_mask;
    end
  end

  assign o_info_bits = o_codeword[K-1:0];

endmodule

// File: tb/tb_ldpc_bitflip_decode.sv
// ----------------------------------------------------------------------------
// tb_ldpc_bitflip_decode
// Self-checking bench for ldpc_bitflip_decode. u_dut0 uses MAX_ITER=8,
// u_dut1 uses MAX_ITER=0. Expected results are queued at accept time and
// compared when o_valid strobes, including latency from accept.
// ----------------------------------------------------------------------------
module tb_ldpc_bitflip_decode;

  localparam logic [17:0] H = 18'h2558B;

  typedef struct {
    logic [5:0] code;
    logic       ok;
    int         iter;
    int         lat;
    int         acc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       v0, v1;
  logic [5:0] w0, w1;
  logic [17:0] h0, h1;
  logic       rdy0, rdy1, ov0, ov1, ok0, ok1;
  logic [5:0] cw0, cw1;
  logic [2:0] ib0, ib1;
`ifdef LDPC_DEC_ITER_CNT_EN
  logic [3:0] it0;
  logic [0:0] it1;
`endif

  int   n_chk  = 0;
  int   n_pass = 0;
  int   cyc    = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t e0, e1;

  ldpc_bitflip_decode #(.N(6), .K(3), .MAX_ITER(8)) u_dut0 (
    .clk(clk), .i_rst_n(rst_n), .i_valid(v0), .o_ready(rdy0), .i_word(w0), .i_h(h0),
    .o_valid(ov0), .o_ok(ok0), .o_codeword(cw0), .o_info_bits(ib0)
`ifdef LDPC_DEC_ITER_CNT_EN
    , .o_iter(it0)
`endif
  );

  ldpc_bitflip_decode #(.N(6), .K(3), .MAX_ITER(0)) u_dut1 (
    .clk(clk), .i_rst_n(rst_n), .i_valid(v1), .o_ready(rdy1), .i_word(w1), .i_h(h1),
    .o_valid(ov1), .o_ok(ok1), .o_codeword(cw1), .o_info_bits(ib1)
`ifdef LDPC_DEC_ITER_CNT_EN
    , .o_iter(it1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Independent behavioural reference of the bit-flipping algorithm.
  function automatic void model(input logic [5:0] w, input logic [17:0] h, input int maxit,
                                output logic [5:0] code, output logic ok, output int it);
    logic [2:0] s;
    int cnt [6];
    int mx;
    code = w; ok = 1'b0; it = 0;
    for (int k = 0; k <= maxit; k++) begin
      it = k;
      s  = '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 6; c++) s[r] = s[r] ^ (h[r*6+c] & code[c]);
      if (s == 3'b000) begin ok = 1'b1; return; end
      if (k == maxit) return;
      mx = 0;
      for (int c = 0; c < 6; c++) begin
        cnt[c] = 0;
        for (int r = 0; r < 3; r++) if (s[r] && h[r*6+c]) cnt[c]++;
        if (cnt[c] > mx) mx = cnt[c];
      end
      for (int c = 0; c < 6; c++) if (cnt[c] == mx) code[c] = ~code[c];
    end
  endfunction

  function automatic exp_t mk(input logic [5:0] code, input logic ok, input int iter);
    exp_t e;
    e.code = code; e.ok = ok; e.iter = iter; e.lat = 2 + 2*iter; e.acc = 0;
    return e;
  endfunction

  // Result monitors: compare every strobe against the head of the scoreboard.
  always @(negedge clk) begin
    if (ov0) begin
      n_chk++;
      if (q0.size() == 0) $display("FAIL dut0_unexpected_valid: got o_valid=1, required no result");
      else begin
        n_pass++;
        e0 = q0.pop_front();
        n_chk++; if (cw0 !== e0.code) $display("FAIL dut0_codeword: got %h, required %h", cw0, e0.code); else n_pass++;
        n_chk++; if (ib0 !== e0.code[2:0]) $display("FAIL dut0_info: got %b, required %b", ib0, e0.code[2:0]); else n_pass++;
        n_chk++; if (ok0 !== e0.ok) $display("FAIL dut0_ok: got %b, required %b", ok0, e0.ok); else n_pass++;
        n_chk++; if (cyc - e0.acc + 1 != e0.lat) $display("FAIL dut0_latency: got %0d, required %0d", cyc - e0.acc + 1, e0.lat); else n_pass++;
`ifdef LDPC_DEC_ITER_CNT_EN
        n_chk++; if (int'(it0) != e0.iter) $display("FAIL dut0_iter: got %0d, required %0d", it0, e0.iter); else n_pass++;
`endif
      end
    end
    if (ov1) begin
      n_chk++;
      if (q1.size() == 0) $display("FAIL dut1_unexpected_valid: got o_valid=1, required no result");
      else begin
        n_pass++;
        e1 = q1.pop_front();
        n_chk++; if (cw1 !== e1.code) $display("FAIL dut1_codeword: got %h, required %h", cw1, e1.code); else n_pass++;
        n_chk++; if (ok1 !== e1.ok) $display("FAIL dut1_ok: got %b, required %b", ok1, e1.ok); else n_pass++;
        n_chk++; if (cyc - e1.acc + 1 != e1.lat) $display("FAIL dut1_latency: got %0d, required %0d", cyc - e1.acc + 1, e1.lat); else n_pass++;
`ifdef LDPC_DEC_ITER_CNT_EN
        n_chk++; if (int'(it1) != e1.iter) $display("FAIL dut1_iter: got %0d, required %0d", it1, e1.iter); else n_pass++;
`endif
      end
    end
  end

  // Drive one word into the selected DUT, queue its expectation at accept,
  // then scramble H to prove it was captured.
  task automatic send(input int sel, input logic [5:0] w, input logic [17:0] h, input exp_t e);
    int   waited = 0;
    logic rdy;
    @(negedge clk);
    if (sel == 0) begin v0 = 1'b1; w0 = w; h0 = h; end
    else          begin v1 = 1'b1; w1 = w; h1 = h; end
    rdy = (sel == 0) ? rdy0 : rdy1;
    while (!rdy && waited < 50) begin
      @(negedge clk); waited++;
      rdy = (sel == 0) ? rdy0 : rdy1;
    end
    n_chk++;
    if (!rdy) begin
      $display("FAIL accept_timeout: got o_ready=0 for %0d cycles, required 1", waited);
      v0 = 1'b0; v1 = 1'b0;
      return;
    end
    n_pass++;
    e.acc = cyc + 1;
    if (sel == 0) q0.push_back(e); else q1.push_back(e);
    @(negedge clk);
    if (sel == 0) begin v0 = 1'b0; h0 = ~h; w0 = ~w; end
    else          begin v1 = 1'b0; h1 = ~h; w1 = ~w; end
  endtask

  task automatic drain();
    int waited = 0;
    while ((q0.size() != 0 || q1.size() != 0) && waited < 100) begin
      @(negedge clk); waited++;
    end
    n_chk++;
    if (q0.size() != 0 || q1.size() != 0)
      $display("FAIL drain_timeout: got %0d/%0d pending, required 0/0", q0.size(), q1.size());
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if (rdy0 !== 1'b1) $display("FAIL reset_ready: got %b, required 1", rdy0); else n_pass++;
    n_chk++; if (ov0 !== 1'b0) $display("FAIL reset_valid: got %b, required 0", ov0); else n_pass++;
    n_chk++; if (ok0 !== 1'b0) $display("FAIL reset_ok: got %b, required 0", ok0); else n_pass++;
    n_chk++; if (cw0 !== 6'h00) $display("FAIL reset_codeword: got %h, required 00", cw0); else n_pass++;
    n_chk++; if (rdy1 !== 1'b1) $display("FAIL reset_ready1: got %b, required 1", rdy1); else n_pass++;
    rst_n = 1'b1;
  endtask

  task automatic test_clean();
    send(0, 6'h1A, H, mk(6'h1A, 1'b1, 0));
    drain();
  endtask

  task automatic test_single_error();
    send(0, 6'h18, H, mk(6'h1A, 1'b1, 1));
    drain();
  endtask

  task automatic test_miscorrection();
    send(0, 6'h3A, H, mk(6'h1D, 1'b1, 2));
    drain();
  endtask

  task automatic test_max_iter_zero();
    send(1, 6'h18, H, mk(6'h18, 1'b0, 0));
    send(1, 6'h1A, H, mk(6'h1A, 1'b1, 0));
    drain();
  endtask

  task automatic test_zero_h();
    send(0, 6'h2D, 18'h0, mk(6'h2D, 1'b1, 0));
    drain();
  endtask

  task automatic test_back_to_back();
    int busy = 0;
    @(negedge clk);
    v0 = 1'b1; w0 = 6'h18; h0 = H;
    n_chk++; if (rdy0 !== 1'b1) $display("FAIL b2b_first_ready: got %b, required 1", rdy0); else n_pass++;
    e0 = mk(6'h1A, 1'b1, 1); e0.acc = cyc + 1; q0.push_back(e0);
    @(negedge clk);
    w0 = 6'h1A;
    while (!rdy0 && busy < 50) begin busy++; @(negedge clk); end
    n_chk++; if (busy != 4) $display("FAIL b2b_busy_cycles: got %0d, required 4", busy); else n_pass++;
    n_chk++; if (q0.size() != 0) $display("FAIL b2b_first_result: got %0d pending, required 0", q0.size()); else n_pass++;
    e0 = mk(6'h1A, 1'b1, 0); e0.acc = cyc + 1; q0.push_back(e0);
    @(negedge clk);
    v0 = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid_decode();
    @(negedge clk);
    v0 = 1'b1; w0 = 6'h3A; h0 = H;
    @(negedge clk);
    v0 = 1'b0;
    @(negedge clk);   // decoder is now in its first FLIP cycle
    rst_n = 1'b0;
    #1;
    n_chk++; if (rdy0 !== 1'b1) $display("FAIL midrst_ready: got %b, required 1", rdy0); else n_pass++;
    n_chk++; if (ov0 !== 1'b0) $display("FAIL midrst_valid: got %b, required 0", ov0); else n_pass++;
    n_chk++; if (ok0 !== 1'b0) $display("FAIL midrst_ok: got %b, required 0", ok0); else n_pass++;
    n_chk++; if (cw0 !== 6'h00) $display("FAIL midrst_codeword: got %h, required 00", cw0); else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);   // any stray strobe is flagged by the monitor
    send(0, 6'h1A, H, mk(6'h1A, 1'b1, 0));
    drain();
  endtask

  task automatic test_random();
    logic [5:0] w, c;
    logic       ok;
    int         it;
    for (int i = 0; i < 10; i++) begin
      w = 6'($urandom);
      model(w, H, 8, c, ok, it);
      send(0, w, H, mk(c, ok, it));
    end
    for (int i = 0; i < 4; i++) begin
      w = 6'($urandom);
      model(w, H, 0, c, ok, it);
      send(1, w, H, mk(c, ok, it));
    end
    drain();
  endtask

  initial begin
    rst_n = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    w0 = '0; w1 = '0; h0 = H; h1 = H;
    test_reset();
    test_clean();
    test_single_error();
    test_miscorrection();
    test_max_iter_zero();
    test_zero_h();
    test_back_to_back();
    test_reset_mid_decode();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
